// File: rtl/encoder_display_mux.sv
// -----------------------------------------------------------------------------
// encoder_display_mux
//   Captures a request vector on a ready handshake, priority-encodes it to the
//   index of its most significant set bit, and shows that index in hex on a
//   free-running multiplexed 7-segment display.
//
// Parameters
//   IN_WIDTH  request-vector width (2..256)
//   DIGITS    number of multiplexed digits (DIGITS*4 >= OUT_WIDTH)
//   SCAN_DIV  clock cycles each digit stays selected (>= 1)
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-low reset
//   ready      capture request (level), honoured only while idle
//   entrada    request vector
//   saida      index of the highest set bit of the captured vector
//   valid      captured vector was non-zero
//   done       one-cycle pulse when saida/valid update
//   busy       high while a capture is in progress or held
//   segments   {g,f,e,d,c,b,a}, active-high
//   digit_sel  one-hot digit enable, active-high
//
// Build option
//   LEADING_ZERO_BLANK_EN  blank leading-zero digits above digit 0
// -----------------------------------------------------------------------------
module encoder_display_mux #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 1000,
  localparam int unsigned OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ready,
  input  logic [IN_WIDTH-1:0]  entrada,
  output logic [OUT_WIDTH-1:0] saida,
  output logic                 valid,
  output logic                 done,
  output logic                 busy,
  output logic [6:0]           segments,
  output logic [DIGITS-1:0]    digit_sel
);

  localparam int unsigned EXT_W = DIGITS * 4;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_DASH  = 7'b1000000;
  localparam logic [6:0]       SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t               state;
  logic [IN_WIDTH-1:0]  cap;
  logic [CNT_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]     dig_idx;

  logic [OUT_WIDTH-1:0] enc_idx;
  logic                 enc_nz;
  logic                 scan_wrap;
  logic [IDX_W-1:0]     dig_nxt;
  logic [OUT_WIDTH-1:0] disp_code;
  logic                 disp_vld;

  // Index of the most significant set bit; later (higher) bits overwrite.
  function automatic logic [OUT_WIDTH-1:0] msb_index(input logic [IN_WIDTH-1:0] v);
    logic [OUT_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      if (v[i]) idx = OUT_WIDTH'(i);
    end
    return idx;
  endfunction

  // Hex font, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Segment pattern for digit idx of the zero-extended code.
  function automatic logic [6:0] digit_pattern(
    input logic [OUT_WIDTH-1:0] code,
    input logic                 vld,
    input logic [IDX_W-1:0]     idx
  );
    logic [EXT_W-1:0] ext;
    logic [6:0]       s;
    ext = EXT_W'(code);
    s   = hex_font(ext[{idx, 2'b00} +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx != '0) && ((ext >> {idx, 2'b00}) == '0)) s = SEG_BLANK;
`endif
    if (!vld) s = SEG_DASH;
    return s;
  endfunction

  // One-hot enable for digit idx.
  function automatic logic [DIGITS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [DIGITS-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  assign enc_idx = msb_index(cap);
  assign enc_nz  = |cap;

  // Next scan position; digit advances only on the counter's terminal count.
  always_comb begin
    scan_wrap = (scan_cnt == CNT_LAST);
    dig_nxt   = dig_idx;
    if (scan_wrap) dig_nxt = (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
  end

  // The display follows the value saida/valid will hold after this edge, so
  // segments never lag the encoder result by a cycle.
  always_comb begin
    disp_code = saida;
    disp_vld  = valid;
    if (state == ENCODE) begin
      disp_code = enc_idx;
      disp_vld  = enc_nz;
    end
  end

  // Control FSM, capture/result registers and display scan.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cap       <= '0;
      saida     <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      scan_cnt  <= '0;
      dig_idx   <= '0;
      digit_sel <= onehot('0);
      segments  <= SEG_BLANK;
    end else begin
      done      <= 1'b0;
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + CNT_W'(1);
      dig_idx   <= dig_nxt;
      digit_sel <= onehot(dig_nxt);
      segments  <= digit_pattern(disp_code, disp_vld, dig_nxt);

      case (state)
        IDLE: begin
          if (ready) begin
            cap   <= entrada;
            state <= ENCODE;
            busy  <= 1'b1;
          end
        end
        ENCODE: begin
          saida <= enc_idx;
          valid <= enc_nz;
          done  <= 1'b1;
          state <= HOLD;
          busy  <= 1'b1;
        end
        HOLD: begin
          // Level handshake: wait for ready to drop before re-arming.
          if (!ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_display_mux.sv
// -----------------------------------------------------------------------------
// tb_encoder_display_mux
//   Directed and randomized bench for encoder_display_mux (IN_WIDTH=16,
//   DIGITS=4, SCAN_DIV=4). A transaction-level model tracks the capture
//   pipeline, the encoded result and the elapsed scan time; every cycle all
//   outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_encoder_display_mux;

  localparam int unsigned IN_WIDTH = 16;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;

  logic        clk;
  logic        reset;
  logic        ready;
  logic [15:0] entrada;
  logic [3:0]  saida;
  logic        valid;
  logic        done;
  logic        busy;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;

  int checks   = 0;
  int failures = 0;

  // Model state
  int          m_phase;      // 0 idle, 1 captured (encoding next), 2 holding
  logic [15:0] m_cap;
  int          m_saida;
  bit          m_valid;
  bit          m_done;
  int          m_scan_t;     // non-reset edges since last reset
  bit          m_after_rst;  // last edge was a reset edge

  logic [6:0] font [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  encoder_display_mux #(
    .IN_WIDTH (IN_WIDTH),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .ready     (ready),
    .entrada   (entrada),
    .saida     (saida),
    .valid     (valid),
    .done      (done),
    .busy      (busy),
    .segments  (segments),
    .digit_sel (digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int msb_of(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        r = i;
        break;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int code, input bit vld, input int d);
    int upper;
    if (!vld) return 7'b1000000;
    upper = code / (1 << (4 * d));
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 0) return 7'b0000000;
`endif
    return font[upper % 16];
  endfunction

  function automatic int cur_digit();
    return (m_scan_t / int'(SCAN_DIV)) % int'(DIGITS);
  endfunction

  // One clock: sample inputs, advance the model, compare every output.
  task automatic tick();
    logic        r, rs;
    logic [15:0] e;
    int          d;
    r  = ready;
    rs = reset;
    e  = entrada;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (!rs) begin
      m_phase = 0; m_cap = '0; m_saida = 0; m_valid = 1'b0;
      m_scan_t = 0; m_after_rst = 1'b1;
    end else begin
      m_after_rst = 1'b0;
      m_scan_t++;
      if (m_phase == 0) begin
        if (r) begin
          m_cap   = e;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_saida = msb_of(m_cap);
        m_valid = (m_cap != 0);
        m_done  = 1'b1;
        m_phase = 2;
      end else if (!r) begin
        m_phase = 0;
      end
    end
    d = cur_digit();
    check("done",      32'(done),      32'(m_done));
    check("busy",      32'(busy),      32'(m_phase != 0));
    check("saida",     32'(saida),     32'(m_saida));
    check("valid",     32'(valid),     32'(m_valid));
    check("digit_sel", 32'(digit_sel), 32'(1 << d));
    check("segments",  32'(segments),
          m_after_rst ? 32'(0) : 32'(exp_seg(m_saida, m_valid, d)));
  endtask

  initial begin
    int          dcount;
    logic [6:0]  upper_exp;
    logic [15:0] r16;

    reset = 1'b0; ready = 1'b0; entrada = '0;
    m_phase = 0; m_cap = '0; m_saida = 0; m_valid = 0; m_done = 0;
    m_scan_t = 0; m_after_rst = 1'b1;

    // Reset held for 3 cycles
    repeat (3) tick();
    check("rst_digit_sel", 32'(digit_sel), 32'h1);
    check("rst_segments",  32'(segments),  32'h0);
    check("rst_busy",      32'(busy),      32'h0);

    // Capture 8421 in the first cycle after reset release
    reset = 1'b1; ready = 1'b1; entrada = 16'h8421;
    tick();
    check("cap_busy", 32'(busy), 32'h1);
    check("cap_done_early", 32'(done), 32'h0);
    ready = 1'b0; entrada = 16'hFFFF;
    tick();
    check("8421_done",  32'(done),  32'h1);
    check("8421_saida", 32'(saida), 32'hF);
    check("8421_valid", 32'(valid), 32'h1);
`ifdef LEADING_ZERO_BLANK_EN
    upper_exp = 7'b0000000;
`else
    upper_exp = 7'b0111111;
`endif
    repeat (16) begin
      tick();
      if (digit_sel == 4'b0001) check("8421_digit0", 32'(segments), 32'b1110001);
      else                      check("8421_upper",  32'(segments), 32'(upper_exp));
    end

    // Zero vector -> dashes on every digit
    ready = 1'b1; entrada = 16'h0000;
    tick();
    ready = 1'b0;
    tick();
    check("zero_done",  32'(done),  32'h1);
    check("zero_saida", 32'(saida), 32'h0);
    check("zero_valid", 32'(valid), 32'h0);
    repeat (16) begin
      tick();
      check("zero_dash", 32'(segments), 32'b1000000);
    end

    // Ready held for 10 cycles with entrada changing: one capture only
    dcount = 0;
    ready = 1'b1; entrada = 16'h0001;
    tick();
    if (done) dcount++;
    entrada = 16'h0100;
    repeat (9) begin
      tick();
      if (done) dcount++;
    end
    check("hold_one_done", 32'(dcount), 32'h1);
    check("hold_saida",    32'(saida),  32'h0);
    check("hold_busy",     32'(busy),   32'h1);
    ready = 1'b0;
    tick();
    check("hold_busy_fall", 32'(busy), 32'h0);

    // Free run
    repeat (20) tick();

    // Reset during ENCODE aborts the capture
    ready = 1'b1; entrada = 16'h4000;
    tick();
    ready = 1'b0; reset = 1'b0;
    tick();
    check("abort_done",  32'(done),  32'h0);
    check("abort_saida", 32'(saida), 32'h0);
    check("abort_valid", 32'(valid), 32'h0);
    check("abort_busy",  32'(busy),  32'h0);
    reset = 1'b1;
    tick();
    check("abort_no_late_done", 32'(done), 32'h0);

    // Randomized traffic with occasional resets
    repeat (400) begin
      reset = ($urandom_range(0, 60) != 0);
      ready = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       entrada = 16'h0000;
        1:       entrada = 16'(32'h1 << $urandom_range(0, 15));
        2:       entrada = 16'($urandom);
        default: begin
          r16 = 16'($urandom);
          entrada = r16 & 16'($urandom) & 16'($urandom);
        end
      endcase
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_display_mux.md
ENCODER_DISPLAY_MUX -- requirements
Module: encoder_display_mux

Interface
REQ-001 Parameter IN_WIDTH, default 16, request-vector width; legal range 2..256.
REQ-002 Parameter DIGITS, default 4, number of multiplexed 7-segment digits; DIGITS*4 SHALL be >= OUT_WIDTH.
REQ-003 Parameter SCAN_DIV, default 1000, clock cycles each digit stays selected; legal range >= 1.
REQ-004 Derived OUT_WIDTH = clog2(IN_WIDTH).
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 ready  in  1  capture request, level handshake.
REQ-008 entrada  in  IN_WIDTH  request vector.
REQ-009 saida  out  OUT_WIDTH  index of the highest set bit of the captured vector.
REQ-010 valid  out  1  captured vector was non-zero.
REQ-011 done  out  1  one-cycle pulse when saida/valid update.
REQ-012 busy  out  1  high while not in IDLE.
REQ-013 segments  out  7  {g,f,e,d,c,b,a}, active-high, registered.
REQ-014 digit_sel  out  DIGITS  one-hot digit enable, active-high, registered.

Function
REQ-015 FSM states IDLE, ENCODE, HOLD; reset state IDLE.
REQ-016 IDLE with ready=1 at an edge: entrada captured into an internal register; go to ENCODE.
REQ-017 ENCODE (exactly 1 cycle): priority-encode the captured vector, register saida/valid, assert done for that one registered cycle; go to HOLD.
REQ-018 done is high in exactly the second cycle after ready was sampled (latency 2); saida/valid are stable from that cycle until the next done.
REQ-019 HOLD: stay while ready=1; go to IDLE when ready=0; ready held high yields exactly one capture.
REQ-020 ready and entrada are ignored outside IDLE.
REQ-021 Captured vector zero: saida=0, valid=0.
REQ-022 Multiple set bits: saida = index of the most significant set bit.
REQ-023 Scan counter counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and digit_sel rotates left by one, DIGITS-1 wrapping to 0.
REQ-024 Scanning is free-running and independent of the FSM; a capture does not restart the scan.
REQ-025 Selected digit i shows hex nibble i of zero-extended saida, font 0-9,A-F, e.g. 0=0111111, F=1110001.
REQ-026 valid=0: every digit shows dash 1000000.
REQ-027 segments and digit_sel update on the same edge, giving no ghosting cycle.

Reset
REQ-028 reset=0 at an edge: FSM to IDLE, scan counter 0, capture register 0.
REQ-029 Reset values: saida=0, valid=0, done=0, busy=0, segments=0000000, digit_sel=one-hot bit 0.
REQ-030 Reset in ENCODE or HOLD aborts the operation; done never pulses for the aborted capture.
REQ-031 ready=1 in the first cycle after reset release is captured normally.

Configuration
REQ-032 Macro LEADING_ZERO_BLANK_EN.
REQ-033 Defined: while valid=1, any digit above digit 0 whose nibble and all higher nibbles are zero shows blank 0000000; digit 0 always shows its value.
REQ-034 Undefined: all digits show their hex nibble, leading zeros included; dash behaviour unchanged.

Verification (IN_WIDTH=16, DIGITS=4, SCAN_DIV=4)
REQ-035 Hold reset=0 for 3 cycles -> all outputs at reset values; digit_sel=0001, segments=0000000.
REQ-036 Pulse ready 1 cycle with entrada=16'h8421 -> done high 2 cycles later, saida=4'hF, valid=1; digit 0 shows 1110001. Digits 1-3 show 0111111 without the macro and 0000000 with it.
REQ-037 entrada=16'h0000 with ready pulse -> saida=0, valid=0; all four digits show 1000000.
REQ-038 ready held high 10 cycles while entrada changes 0001->0100 -> exactly one done, saida=0; busy falls 1 cycle after ready falls.
REQ-039 Free run 20 cycles -> digit_sel 0001,0010,0100,1000,0001, each held 4 cycles.
REQ-040 reset=0 in the ENCODE cycle -> no done, saida=0, valid=0, FSM in IDLE.
